ratio_decoder: RTL

RATIO_DECODER -- requirements
Module: ratio_decoder

---
 rtl/ratio_decoder_pkg.sv | 19 +
 rtl/ratio_decoder_if.sv | 26 ++
 rtl/pow2_encode.sv | 21 ++
 rtl/ratio_decoder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ratio_decoder_pkg.sv
// rtl/ratio_decoder_pkg.sv - shared types and sizes for the divider ratio decoder
package ratio_decoder_pkg;

    localparam int MAX_PERIOD = 256;
    localparam int CNT_W      = 9;
    localparam int CODE_W     = 4;
    localparam int MATCH_W    = 3;

    // Counter parks here when no tick arrives; one past the longest legal period.
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_PERIOD + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

endpackage

// File: rtl/ratio_decoder_if.sv
// rtl/ratio_decoder_if.sv - enable/tick inputs and decoded ratio outputs
interface ratio_decoder_if;

    logic                                en;
    logic                                tick_in;
    logic [ratio_decoder_pkg::CODE_W-1:0] div_val;
    logic                                locked;
    logic                                err;

    modport master (
        output en,
        output tick_in,
        input  div_val,
        input  locked,
        input  err
    );

    modport slave (
        input  en,
        input  tick_in,
        output div_val,
        output locked,
        output err
    );

endinterface

// File: rtl/pow2_encode.sv
// rtl/pow2_encode.sv - maps a measured period to {valid, n} when period == 2^n, n in 1..8
module pow2_encode
    import ratio_decoder_pkg::*;
(
    input  logic [CNT_W-1:0]  period,
    output logic              valid,
    output logic [CODE_W-1:0] code
);

    always_comb begin
        valid = 1'b0;
        code  = '0;
        for (int i = 1; i <= 8; i++) begin
            if (period == (CNT_W'(1) << i)) begin
                valid = 1'b1;
                code  = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/ratio_decoder.sv
// rtl/ratio_decoder.sv - measures the tick period, locks onto a stable 2^n ratio and reports n
module ratio_decoder
    import ratio_decoder_pkg::*;
#(
    parameter int LOCK_CNT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    ratio_decoder_if.slave bus
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] SYNC    = ST_SYNC;
    localparam logic [1:0] MEASURE = ST_MEASURE;
    localparam logic [1:0] LOCKED  = ST_LOCKED;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [CODE_W-1:0]  cand;
    logic               cand_vld;
    logic [MATCH_W-1:0] match;
    logic [CODE_W-1:0]  div_q;
    logic               locked_q;
    logic               err_q;

    logic               p_valid;
    logic [CODE_W-1:0]  p_code;
    logic [MATCH_W:0]   match_nx;
    logic               lock_hit;
    logic               overrun;
    logic [CNT_W-1:0]   cnt_inc;

    // cnt holds the period length as seen on the edge that samples the next tick
    pow2_encode u_enc (
        .period (cnt),
        .valid  (p_valid),
        .code   (p_code)
    );

    always_comb begin
        match_nx = (cand_vld && (cand == p_code)) ? ({1'b0, match} + 1'b1)
                                                  : (MATCH_W+1)'(1);
        lock_hit = (match_nx >= (MATCH_W+1)'(LOCK_CNT));
        overrun  = !bus.tick_in && (cnt == CNT_W'(MAX_PERIOD));
        cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cand     <= '0;
            cand_vld <= 1'b0;
            match    <= '0;
            div_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (!bus.en) begin
                state    <= IDLE;
                cnt      <= '0;
                cand     <= '0;
                cand_vld <= 1'b0;
                match    <= '0;
                div_q    <= '0;
                locked_q <= 1'b0;
            end else begin
                case (state)
                    // a tick seen while leaving IDLE already serves as the sync tick
                    IDLE, SYNC: begin
                        if (bus.tick_in) begin
                            state    <= MEASURE;
                            cnt      <= CNT_W'(1);
                            cand_vld <= 1'b0;
                            match    <= '0;
                        end else begin
                            state <= SYNC;
                            cnt   <= '0;
                        end
                    end
                    MEASURE: begin
                        if (bus.tick_in) begin
                            cnt <= CNT_W'(1);
                            if (!p_valid) begin
                                err_q    <= 1'b1;
                                cand_vld <= 1'b0;
                                match    <= '0;
                            end else begin
                                cand     <= p_code;
                                cand_vld <= 1'b1;
                                match    <= match_nx[MATCH_W-1:0];
                                if (lock_hit) begin
                                    state    <= LOCKED;
                                    locked_q <= 1'b1;
                                    div_q    <= p_code;
                                end
                            end
                        end else if (overrun) begin
                            err_q    <= 1'b1;
                            state    <= SYNC;
                            cnt      <= '0;
                            cand_vld <= 1'b0;
                            match    <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    LOCKED: begin
                        if (bus.tick_in) begin
                            cnt <= CNT_W'(1);
                            if (!(p_valid && (p_code == div_q))) begin
                                err_q    <= 1'b1;
                                locked_q <= 1'b0;
                                div_q    <= '0;
                                state    <= MEASURE;
                                cand     <= p_code;
                                cand_vld <= p_valid;
                                match    <= p_valid ? MATCH_W'(1) : '0;
                            end
                        end else if (overrun) begin
                            err_q    <= 1'b1;
                            locked_q <= 1'b0;
                            div_q    <= '0;
                            state    <= SYNC;
                            cnt      <= '0;
                            cand_vld <= 1'b0;
                            match    <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.div_val = div_q;
    assign bus.locked  = locked_q;
    assign bus.err     = err_q;

endmodule
